// File: rtl/adc_sar_pkg.sv
// adc_sar_pkg: shared state/op encodings and constants
// for the 12-bit SAR ADC controller.
package adc_sar_pkg;

    localparam int ADC_RESOLUTION = 12;
    localparam logic [ADC_RESOLUTION-1:0] DAC_MIDCODE = 12'h800;

    // Comparator synchronizer depth; 0 for an already-registered comparator.
    localparam int COMP_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        COMPARE,
        DECIDE,
        DONE
    } sar_state_e;

    typedef enum logic [1:0] {
        REG_HOLD,
        REG_LOAD,
        REG_APPLY
    } sar_reg_op_e;

    function automatic logic [ADC_RESOLUTION-1:0] sar_midcode();
        return DAC_MIDCODE;
    endfunction

endpackage

// File: rtl/adc_sar_control_if.sv
// adc_sar_if: host/analog-side signal bundle of the SAR controller.
// The slave modport is the controller's view.
interface adc_sar_if #(
    parameter int RESOLUTION = 12,
    parameter int SAMPLE_W   = 8
);
    logic                  start_i;
    logic [SAMPLE_W-1:0]   sample_cycles_i;
    logic                  comp_p_i;
    logic                  comp_n_i;
    logic                  sample_o;
    logic                  comp_clk_o;
    logic [RESOLUTION-1:0] dac_p_o;
    logic [RESOLUTION-1:0] dac_n_o;
    logic [RESOLUTION-1:0] result_o;
    logic                  valid_o;
    logic                  busy_o;
    logic                  timeout_o;

    modport master (
        output start_i,
        output sample_cycles_i,
        output comp_p_i,
        output comp_n_i,
        input  sample_o,
        input  comp_clk_o,
        input  dac_p_o,
        input  dac_n_o,
        input  result_o,
        input  valid_o,
        input  busy_o,
        input  timeout_o
    );

    modport slave (
        input  start_i,
        input  sample_cycles_i,
        input  comp_p_i,
        input  comp_n_i,
        output sample_o,
        output comp_clk_o,
        output dac_p_o,
        output dac_n_o,
        output result_o,
        output valid_o,
        output busy_o,
        output timeout_o
    );

endinterface

// File: rtl/adc_sar_control_register.sv
// adc_sar_register: SAR trial/decision register and bit pointer k.
// Ops: load midcode, apply decision and advance to the next trial bit.
module adc_sar_register
    import adc_sar_pkg::*;
#(
    parameter int RES = ADC_RESOLUTION
) (
    input  logic           clk,
    input  logic           rst_n,
    input  sar_reg_op_e    op_i,
    input  logic           d_i,
    output logic [RES-1:0] code_o,
    output logic           last_o
);

    localparam int KW = $clog2(RES);
    localparam logic [RES-1:0] MID = {1'b1, {(RES-1){1'b0}}};
    localparam logic [KW-1:0]  KTOP = KW'(RES - 1);

    logic [RES-1:0] code_q, code_d;
    logic [KW-1:0]  k_q, k_d;

    always_comb begin
        code_d = code_q;
        k_d    = k_q;
        unique case (op_i)
            REG_LOAD: begin
                code_d = MID;
                k_d    = KTOP;
            end
            REG_APPLY: begin
                code_d[k_q] = d_i;
                // Next trial bit is raised in the same step as the decision.
                if (k_q != '0) begin
                    k_d         = k_q - 1'b1;
                    code_d[k_d] = 1'b1;
                end
            end
            default: begin
                code_d = code_q;
                k_d    = k_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= MID;
            k_q    <= KTOP;
        end else begin
            code_q <= code_d;
            k_q    <= k_d;
        end
    end

    assign code_o = code_q;
    assign last_o = (k_q == '0);

endmodule

// File: rtl/adc_sar_control.sv
// adc_sar_control: SAR ADC sequencer -- sample, 12 MSB-first trials,
// registered result/valid toward the host and trial code toward the DAC decoders.
module adc_sar_control
    import adc_sar_pkg::*;
#(
    parameter int RESOLUTION   = ADC_RESOLUTION,
    parameter int SAMPLE_W     = 8,
    parameter int COMP_TIMEOUT = 15
) (
    input  logic    clk,
    input  logic    rst_n,
    adc_sar_if.slave bus
);

    localparam int TW = $clog2(COMP_TIMEOUT + 1);

    sar_state_e            state_q;
    logic [SAMPLE_W-1:0]   scnt_q;
    logic [TW-1:0]         tcnt_q;
    logic                  d_q;
    logic [RESOLUTION-1:0] result_q;
    logic                  sample_q;
    logic                  comp_clk_q;
    logic                  valid_q;
    logic                  busy_q;
    logic                  timeout_q;

    sar_reg_op_e           reg_op;
    logic [RESOLUTION-1:0] code;
    logic                  last;
    logic                  comp_p_s;
    logic                  comp_n_s;
    logic                  decided;

    generate
        if (COMP_SYNC_STAGES == 0) begin : g_nosync
            assign comp_p_s = bus.comp_p_i;
            assign comp_n_s = bus.comp_n_i;
        end else begin : g_sync
            logic [COMP_SYNC_STAGES-1:0] p_q;
            logic [COMP_SYNC_STAGES-1:0] n_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    p_q <= '0;
                    n_q <= '0;
                end else begin
                    p_q[0] <= bus.comp_p_i;
                    n_q[0] <= bus.comp_n_i;
                    for (int i = 1; i < COMP_SYNC_STAGES; i++) begin
                        p_q[i] <= p_q[i-1];
                        n_q[i] <= n_q[i-1];
                    end
                end
            end

            assign comp_p_s = p_q[COMP_SYNC_STAGES-1];
            assign comp_n_s = n_q[COMP_SYNC_STAGES-1];
        end
    endgenerate

    // Both-low or both-high is an undecided comparator.
    assign decided = comp_p_s ^ comp_n_s;

    always_comb begin
        reg_op = REG_HOLD;
        unique case (state_q)
            IDLE, DONE: reg_op = REG_LOAD;
            DECIDE:     reg_op = REG_APPLY;
            default:    reg_op = REG_HOLD;
        endcase
    end

    adc_sar_register #(
        .RES(RESOLUTION)
    ) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .op_i  (reg_op),
        .d_i   (d_q),
        .code_o(code),
        .last_o(last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            scnt_q     <= '0;
            tcnt_q     <= '0;
            d_q        <= 1'b0;
            result_q   <= '0;
            sample_q   <= 1'b0;
            comp_clk_q <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        state_q   <= SAMPLE;
                        scnt_q    <= (bus.sample_cycles_i == '0) ? '0
                                   : bus.sample_cycles_i - 1'b1;
                        timeout_q <= 1'b0;
                        sample_q  <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                SAMPLE: begin
                    if (scnt_q == '0) begin
                        state_q    <= COMPARE;
                        sample_q   <= 1'b0;
                        comp_clk_q <= 1'b1;
                        tcnt_q     <= '0;
                    end else begin
                        scnt_q <= scnt_q - 1'b1;
                    end
                end
                COMPARE: begin
                    if (decided) begin
                        d_q        <= comp_p_s;
                        state_q    <= DECIDE;
                        comp_clk_q <= 1'b0;
                    end else if (tcnt_q == TW'(COMP_TIMEOUT - 1)) begin
                        d_q        <= 1'b0;
                        timeout_q  <= 1'b1;
                        state_q    <= DECIDE;
                        comp_clk_q <= 1'b0;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                DECIDE: begin
                    if (last) begin
                        state_q  <= DONE;
                        result_q <= {code[RESOLUTION-1:1], d_q};
                        valid_q  <= 1'b1;
                    end else begin
                        state_q    <= COMPARE;
                        comp_clk_q <= 1'b1;
                        tcnt_q     <= '0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.sample_o   = sample_q;
    assign bus.comp_clk_o = comp_clk_q;
    assign bus.dac_p_o    = code;
    assign bus.dac_n_o    = ~code;
    assign bus.result_o   = result_q;
    assign bus.valid_o    = valid_q;
    assign bus.busy_o     = busy_q;
    assign bus.timeout_o  = timeout_q;

endmodule

// File: tb/tb_adc_sar_control.sv
// tb_adc_sar_control: directed vectors for the SAR controller with a
// comparator model that answers two cycles early to cover the synchronizer.
module tb_adc_sar_control;
    import adc_sar_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adc_sar_if #(.RESOLUTION(12), .SAMPLE_W(8)) bus ();

    adc_sar_control #(
        .RESOLUTION  (12),
        .SAMPLE_W    (8),
        .COMP_TIMEOUT(15)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int t0 = 1000000;
    int mode = 0;
    int s_m = 1;
    logic [11:0] vin = '0;

    int n_d;
    int j_d;
    logic p_d;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decision for trial j: Vin >= (decided upper bits of Vin | trial bit).
    function automatic logic comp_model(input int j);
        int k;
        int v;
        int trial;
        k = 11 - j;
        v = int'({20'b0, vin});
        trial = ((v >> (k + 1)) << (k + 1)) | (1 << k);
        return v >= trial;
    endfunction

    // Trial index whose decision must be captured at edge n+1.
    function automatic int jsel(input int n, input int s);
        int x;
        x = n + 2 - s;
        if (x < 0) return 0;
        x = x / 2;
        if (x > 11) x = 11;
        return x;
    endfunction

    always @(negedge clk) begin
        #1;
        n_d = cyc - t0;
        case (mode)
            1: begin
                j_d = jsel(n_d, s_m);
                p_d = comp_model(j_d);
                bus.comp_p_i = p_d;
                bus.comp_n_i = !p_d;
            end
            3: begin
                if (n_d + 1 >= s_m - 1 && n_d + 1 <= s_m + 1) begin
                    bus.comp_p_i = 1'b1;
                    bus.comp_n_i = 1'b1;
                end else begin
                    j_d = jsel(n_d, s_m + 3);
                    p_d = comp_model(j_d);
                    bus.comp_p_i = p_d;
                    bus.comp_n_i = !p_d;
                end
            end
            default: begin
                bus.comp_p_i = 1'b0;
                bus.comp_n_i = 1'b0;
            end
        endcase
    end

    task automatic start_conv(input logic [11:0] v, input int sc,
                              input int m, input bit hold);
        @(negedge clk);
        vin = v;
        bus.sample_cycles_i = 8'(sc);
        s_m = (sc == 0) ? 1 : sc;
        mode = m;
        t0 = cyc + 1;
        bus.start_i = 1'b1;
        @(negedge clk);
        if (!hold) bus.start_i = 1'b0;
    endtask

    task automatic wait_rel(input int r);
        while (cyc - t0 < r) @(negedge clk);
    endtask

    task automatic wait_valid(input int maxc, output int at);
        at = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (bus.valid_o) begin
                at = cyc - t0;
                break;
            end
        end
        chk("valid_seen", {31'b0, bus.valid_o}, 1);
    endtask

    initial begin
        int at;
        int nv;
        bus.start_i = 1'b0;
        bus.sample_cycles_i = '0;

        // Power-on reset state
        #12;
        chk("rst_dac_p", bus.dac_p_o, 12'h800);
        chk("rst_dac_n", bus.dac_n_o, 12'h7FF);
        chk("rst_result", bus.result_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_valid", bus.valid_o, 0);
        chk("rst_sample", bus.sample_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // A5C, S=4, immediate comparator
        start_conv(12'hA5C, 4, 1, 1'b0);
        chk("t2_busy0", bus.busy_o, 1);
        chk("t2_sample0", bus.sample_o, 1);
        wait_rel(3);
        chk("t2_sample3", bus.sample_o, 1);
        wait_rel(4);
        chk("t2_sample4", bus.sample_o, 0);
        chk("t2_cclk4", bus.comp_clk_o, 1);
        chk("t2_dac4", bus.dac_p_o, 12'h800);
        wait_rel(5);
        chk("t2_cclk5", bus.comp_clk_o, 0);
        wait_rel(6);
        chk("t2_dac6", bus.dac_p_o, 12'hC00);
        chk("t2_cclk6", bus.comp_clk_o, 1);
        wait_rel(8);
        chk("t2_dac8", bus.dac_p_o, 12'hA00);
        wait_rel(10);
        chk("t2_dac10", bus.dac_p_o, 12'hB00);
        chk("t2_dacn10", bus.dac_n_o, 12'h4FF);
        wait_rel(27);
        chk("t2_valid27", bus.valid_o, 0);
        wait_rel(28);
        chk("t2_valid28", bus.valid_o, 1);
        chk("t2_result", bus.result_o, 12'hA5C);
        wait_rel(29);
        chk("t2_valid29", bus.valid_o, 0);
        chk("t2_busy29", bus.busy_o, 0);
        chk("t2_dac29", bus.dac_p_o, 12'h800);

        // Back-to-back FFF then 000 with start held high
        start_conv(12'hFFF, 2, 1, 1'b1);
        wait_rel(26);
        chk("t3_valid_a", bus.valid_o, 1);
        chk("t3_result_a", bus.result_o, 12'hFFF);
        vin = 12'h000;
        t0 = t0 + 28;
        wait_rel(-1);
        chk("t3_idle_busy", bus.busy_o, 0);
        chk("t3_idle_valid", bus.valid_o, 0);
        wait_rel(0);
        chk("t3_restart_busy", bus.busy_o, 1);
        wait_rel(26);
        chk("t3_valid_b", bus.valid_o, 1);
        chk("t3_result_b", bus.result_o, 12'h000);
        chk("t3_timeout", bus.timeout_o, 0);
        bus.start_i = 1'b0;

        // Silent comparator, every trial times out
        start_conv(12'h123, 4, 2, 1'b0);
        wait_rel(18);
        chk("t4_to18", bus.timeout_o, 0);
        chk("t4_cclk18", bus.comp_clk_o, 1);
        wait_rel(19);
        chk("t4_to19", bus.timeout_o, 1);
        chk("t4_cclk19", bus.comp_clk_o, 0);
        wait_rel(195);
        chk("t4_valid195", bus.valid_o, 0);
        wait_rel(196);
        chk("t4_valid196", bus.valid_o, 1);
        chk("t4_result", bus.result_o, 0);
        chk("t4_timeout", bus.timeout_o, 1);

        // Both comparator outputs high for 3 cycles first
        start_conv(12'h3C5, 3, 3, 1'b0);
        chk("t5_to_clr", bus.timeout_o, 0);
        wait_valid(80, at);
        chk("t5_lat", at, 30);
        chk("t5_result", bus.result_o, 12'h3C5);

        // Async reset mid-trial at k=7
        start_conv(12'h6B1, 4, 2, 1'b0);
        wait_rel(70);
        chk("t1_pre_dac", bus.dac_p_o, 12'h080);
        chk("t1_pre_to", bus.timeout_o, 1);
        rst_n = 1'b0;
        #1;
        chk("t1_dac_p", bus.dac_p_o, 12'h800);
        chk("t1_dac_n", bus.dac_n_o, 12'h7FF);
        chk("t1_busy", bus.busy_o, 0);
        chk("t1_result", bus.result_o, 0);
        chk("t1_timeout", bus.timeout_o, 0);
        chk("t1_cclk", bus.comp_clk_o, 0);
        mode = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // sample_cycles_i=0, stray start pulses while busy
        start_conv(12'h5A3, 0, 1, 1'b0);
        nv = 0;
        at = -1;
        for (int r = 1; r <= 40; r++) begin
            wait_rel(r);
            if (bus.valid_o) begin
                nv++;
                at = r;
            end
            bus.start_i = (r == 4 || r == 19);
        end
        chk("t6_nvalid", nv, 1);
        chk("t6_lat", at, 25);
        chk("t6_result", bus.result_o, 12'h5A3);
        chk("t6_idle", bus.busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
